// File: rtl/wb_classic_fifo_device.sv
// Wishbone B4 classic device fronting a small FIFO: writes push, reads pop.
// Optional macro WB_ASYNC_ACK_EN: same-cycle responses when WAIT_STATES == 0.
module wb_classic_fifo_device #(
  parameter int DAT_WIDTH   = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [DAT_WIDTH-1:0]       dat_i,
  output logic                       ack_o,
  output logic                       err_o,
  output logic                       rty_o,
  output logic [DAT_WIDTH-1:0]       dat_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // The counter is loaded one short so the response lands WAIT_STATES+1 cycles after the request.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef WB_ASYNC_ACK_EN
  localparam bit ASYNC = (WAIT_STATES == 0);
`else
  localparam bit ASYNC = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic              req, respond, full, empty, push, pop;

  assign req     = cyc_i && stb_i;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign level_o = level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    respond    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (ASYNC) begin
            respond = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req)            state_next = S_IDLE;
        else if (cnt == '0)  state_next = S_RESP;
        else                 cnt_next   = cnt - 4'd1;
      end
      S_RESP: begin
        if (!req) begin
          state_next = S_IDLE;
        end else begin
          respond    = 1'b1;
          state_next = S_HOLD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o = 1'b0;
    err_o = 1'b0;
    rty_o = 1'b0;
    dat_o = '0;
    push  = 1'b0;
    pop   = 1'b0;
    if (respond) begin
      if (we_i) begin
        if (full) begin
          rty_o = 1'b1;
        end else begin
          ack_o = 1'b1;
          push  = 1'b1;
        end
      end else if (empty) begin
        err_o = 1'b1;
      end else begin
        ack_o = 1'b1;
        pop   = 1'b1;
        dat_o = mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        level  <= level + LW'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        level  <= level - LW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dat_i;
  end

endmodule

// File: tb/tb_wb_classic_fifo_device.sv
// Directed bench for wb_classic_fifo_device: one zero-wait and one three-wait instance.
// Expected latencies follow WB_ASYNC_ACK_EN when the bench is built with it.
module tb_wb_classic_fifo_device;

`ifdef WB_ASYNC_ACK_EN
  localparam int L0 = 0;
`else
  localparam int L0 = 1;
`endif
  localparam int L1 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cyc0 = 1'b0, cyc1 = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0] dat = '0;
  logic       ack0, err0, rty0, ack1, err1, rty1;
  logic [7:0] dat_o0, dat_o1;
  logic [2:0] level0, level1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_classic_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc0), .stb_i(stb), .we_i(we), .dat_i(dat),
    .ack_o(ack0), .err_o(err0), .rty_o(rty0), .dat_o(dat_o0), .level_o(level0)
  );

  wb_classic_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc1), .stb_i(stb), .we_i(we), .dat_i(dat),
    .ack_o(ack1), .err_o(err1), .rty_o(rty1), .dat_o(dat_o1), .level_o(level1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [1:0] k, output logic [7:0] d,
                        output int n, output logic [2:0] lv);
    logic a, e, r;
    if (sel == 0) begin a = ack0; e = err0; r = rty0; d = dat_o0; lv = level0; end
    else          begin a = ack1; e = err1; r = rty1; d = dat_o1; lv = level1; end
    n = int'(a) + int'(e) + int'(r);
    k = a ? 2'd1 : (e ? 2'd2 : (r ? 2'd3 : 2'd0));
  endtask

  // kind: 1 = ack, 2 = err, 3 = rty
  task automatic xfer(input int sel, input logic w, input logic [7:0] d, input int exp_lat,
                      input logic [1:0] exp_kind, input logic [7:0] exp_dat, input int exp_lvl,
                      input bit hold_chk, input string tag);
    logic [1:0] k;
    logic [7:0] rd;
    logic [2:0] lv;
    int n, lat;
    bit got;
    we = w; dat = d; stb = 1'b1;
    if (sel == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
    lat = 0; got = 1'b0; k = '0; rd = '0; n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #2;
      sample(sel, k, rd, n, lv);
      if (n != 0) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, "_responded"}, int'(got), 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_one_resp"}, n, 1);
    check({tag, "_kind"}, int'(k), int'(exp_kind));
    check({tag, "_dat"}, int'(rd), int'(exp_dat));
    @(posedge clk); #1;
    if (hold_chk) begin
      #2;
      sample(sel, k, rd, n, lv);
      check({tag, "_hold_idle"}, n, 0);
      @(posedge clk); #1;
    end
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0; dat = '0;
    #2;
    sample(sel, k, rd, n, lv);
    check({tag, "_level"}, int'(lv), exp_lvl);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    #3;
    check("rst_ack", int'(ack0 | ack1), 0);
    check("rst_err", int'(err0 | err1), 0);
    check("rst_rty", int'(rty0 | rty1), 0);
    check("rst_dat", int'(dat_o0 | dat_o1), 0);
    check("rst_level", int'(level0 | level1), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, 1'b1, 8'hA5, L0, 2'd1, 8'h00, 1, 1'b0, "wr_a5");
    xfer(0, 1'b1, 8'h3C, L0, 2'd1, 8'h00, 2, 1'b0, "wr_3c");
    xfer(0, 1'b0, 8'h00, L0, 2'd1, 8'hA5, 1, 1'b0, "rd_a5");
    xfer(0, 1'b0, 8'h00, L0, 2'd1, 8'h3C, 0, 1'b0, "rd_3c");
    xfer(0, 1'b0, 8'h00, L0, 2'd2, 8'h00, 0, 1'b0, "rd_empty");

    xfer(0, 1'b1, 8'h11, L0, 2'd1, 8'h00, 1, 1'b0, "fill1");
    xfer(0, 1'b1, 8'h22, L0, 2'd1, 8'h00, 2, 1'b0, "fill2");
    xfer(0, 1'b1, 8'h33, L0, 2'd1, 8'h00, 3, 1'b0, "fill3");
    xfer(0, 1'b1, 8'h44, L0, 2'd1, 8'h00, 4, 1'b0, "fill4");
    xfer(0, 1'b1, 8'h55, L0, 2'd3, 8'h00, 4, 1'b0, "fill5_full");
    xfer(0, 1'b0, 8'h00, L0, 2'd1, 8'h11, 3, 1'b0, "drain1");
    xfer(0, 1'b0, 8'h00, L0, 2'd1, 8'h22, 2, 1'b0, "drain2");
    xfer(0, 1'b0, 8'h00, L0, 2'd1, 8'h33, 1, 1'b0, "drain3");
    xfer(0, 1'b0, 8'h00, L0, 2'd1, 8'h44, 0, 1'b0, "drain4");

    xfer(1, 1'b1, 8'h11, L1, 2'd1, 8'h00, 1, 1'b1, "ws3_wr11");
    xfer(1, 1'b1, 8'h22, L1, 2'd1, 8'h00, 2, 1'b0, "ws3_wr22");

    // Reset while a read sits in WAIT with two entries stored.
    we = 1'b0; stb = 1'b1; cyc1 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rstw_ack", int'(ack1), 0);
    check("rstw_err", int'(err1), 0);
    check("rstw_dat", int'(dat_o1), 0);
    check("rstw_level", int'(level1), 0);
    cyc1 = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #3;
      seen += int'(ack1) + int'(err1) + int'(rty1);
    end
    check("rstw_no_resp", seen, 0);
    check("rstw_level_after", int'(level1), 0);
    #1;

`ifdef WB_ASYNC_ACK_EN
    xfer(0, 1'b1, 8'h01, 0, 2'd1, 8'h00, 1, 1'b0, "as_wr1");
    xfer(0, 1'b1, 8'h02, 0, 2'd1, 8'h00, 2, 1'b0, "as_wr2");
    xfer(0, 1'b1, 8'h03, 0, 2'd1, 8'h00, 3, 1'b0, "as_wr3");
    we = 1'b0; stb = 1'b1; cyc0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("as_rd_ack", int'(ack0), 1);
      check("as_rd_dat", int'(dat_o0), i + 1);
      @(posedge clk); #1;
    end
    cyc0 = 1'b0; stb = 1'b0;
    #2;
    check("as_level", int'(level0), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
